reg_wb_queue: RTL and testbench



---
 rtl/reg_wb_pkg.sv | 21 ++
 rtl/wb_entry_fifo.sv | 90 +++++++++
 rtl/reg_wb_queue.sv | 105 ++++++++++
 tb/tb_reg_wb_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_pkg
// Shared constants and the queue entry type for the register-file write-back
// queue.
//   AW    : register address width (32 registers)
//   DW    : register data width
//   DEPTH : default number of queue entries (power of two, >= 2)
//   wb_entry_t : one pending write-back {addr, data}
// -----------------------------------------------------------------------------
package reg_wb_pkg;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// -----------------------------------------------------------------------------
// wb_entry_fifo
// Circular FIFO of pending write-backs. Owns the pointers, the occupancy count,
// the entry storage and the accept/drain decisions, and exports the whole entry
// array plus a valid mask so the parent can search it for read bypass.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : producer offers in_entry this cycle
//   in_ready      : queue takes the offer this cycle
//   in_entry      : {addr, data} being offered
//   hold          : register-file write port unavailable, no drain this cycle
//   pop           : head entry is committed at the coming posedge
//   entries       : raw storage, indexed by slot
//   valid_mask    : bit i set when slot i holds a pending entry
//   head          : slot of the oldest pending entry
//   count         : number of pending entries
//   empty         : count == 0
//
// Handshake: a transfer happens on a posedge where in_valid && in_ready are
// both high. in_ready never depends on in_valid, so the producer may look at
// in_ready before deciding what to offer. Once offered, the producer holds
// in_entry stable until the transfer. A transfer to address 0 completes the
// handshake but is dropped, since register 0 is hard-wired to zero.
// -----------------------------------------------------------------------------
module wb_entry_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = reg_wb_pkg::DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  wb_entry_t                    in_entry,
    input  logic                         hold,
    output logic                         pop,
    output wb_entry_t                    entries [DEPTH],
    output logic [DEPTH-1:0]             valid_mask,
    output logic [$clog2(DEPTH)-1:0]     head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] tail;
    logic          push;

    assign empty    = (count == '0);
    assign pop      = !empty && !hold;
    // A draining head frees its slot at the same edge, so a full queue can
    // still accept when it is also committing.
    assign in_ready = (count < CW'(DEPTH)) || pop;
    assign push     = in_valid && in_ready && (in_entry.addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail] <= in_entry;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is pending when its distance from head (mod DEPTH) is below count.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = (CW'(PW'(PW'(i) - head)) < count);
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
// Write-back queue in front of the single write port of the 32x32 register
// file. Buffers write-back requests, drains one per cycle into A3/WD/We, and
// forwards still-pending data onto the two read ports so decode always sees
// the newest value of every register.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : write-back request handshake
//   in_addr, in_data    : destination register and value
//   hold                : write port borrowed elsewhere, no drain this cycle
//   A3, WD, We          : register-file write port (head entry)
//   A1, A2              : decode read addresses (also go to the register file)
//   RD1_rf, RD2_rf      : raw register-file read data
//   RD1, RD2            : read data with pending write-backs forwarded
//   count, empty        : occupancy
//
// Widths of addresses and data come from reg_wb_pkg; only DEPTH is tunable.
// -----------------------------------------------------------------------------
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = reg_wb_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       hold,
    output logic [AW-1:0]              A3,
    output logic [DW-1:0]              WD,
    output logic                       We,
    input  logic [AW-1:0]              A1,
    input  logic [AW-1:0]              A2,
    input  logic [DW-1:0]              RD1_rf,
    input  logic [DW-1:0]              RD2_rf,
    output logic [DW-1:0]              RD1,
    output logic [DW-1:0]              RD2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t          in_entry;
    wb_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid_mask;
    logic [PW-1:0]      head;
    logic               pop;
    logic [PW-1:0]      idx;

    assign in_entry.addr = in_addr;
    assign in_entry.data = in_data;

    wb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_entry   (in_entry),
        .hold       (hold),
        .pop        (pop),
        .entries    (entries),
        .valid_mask (valid_mask),
        .head       (head),
        .count      (count),
        .empty      (empty)
    );

    // Storage under head is stale when empty, so the write port is forced to 0.
    assign We = pop;
    assign A3 = empty ? '0 : entries[head].addr;
    assign WD = empty ? '0 : entries[head].data;

    // Walk the slots oldest to newest; each later hit overrides the previous
    // one, so the newest matching entry wins. The head entry committing this
    // cycle is still in the mask and still forwards. A request being pushed
    // this cycle is not in storage yet and is not seen.
    always_comb begin
        RD1 = RD1_rf;
        RD2 = RD2_rf;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid_mask[idx] && (entries[idx].addr == A1)) begin
                RD1 = entries[idx].data;
            end
            if (valid_mask[idx] && (entries[idx].addr == A2)) begin
                RD2 = entries[idx].data;
            end
        end
        if (A1 == '0) begin
            RD1 = '0;
        end
        if (A2 == '0) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_queue
// Self-checking bench for reg_wb_queue. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A monitor keeps the
// scoreboard: every accepted non-zero request is queued as {addr, data} and
// every We pulse must match the front of that queue.
// -----------------------------------------------------------------------------
module tb_reg_wb_queue;
    import reg_wb_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          hold;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD;
    logic          We;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1_rf;
    logic [DW-1:0] RD2_rf;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic [CW-1:0] count;
    logic          empty;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_commits = 0;

    logic [AW+DW-1:0] exp_q[$];

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .A3       (A3),
        .WD       (WD),
        .We       (We),
        .A1       (A1),
        .A2       (A2),
        .RD1_rf   (RD1_rf),
        .RD2_rf   (RD2_rf),
        .RD1      (RD1),
        .RD2      (RD2),
        .count    (count),
        .empty    (empty)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (We) begin
                n_checks++;
                n_commits++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_order: got We with A3=%0d WD=%h, expected no commit", A3, WD);
                end else begin
                    logic [AW+DW-1:0] exp;
                    exp = exp_q.pop_front();
                    if ({A3, WD} !== exp) begin
                        n_fail++;
                        $display("FAIL commit_order: got A3=%0d WD=%h, expected A3=%0d WD=%h",
                                 A3, WD, exp[AW+DW-1:DW], exp[DW-1:0]);
                    end
                end
            end
            if (in_valid && in_ready && (in_addr != '0)) begin
                exp_q.push_back({in_addr, in_data});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_rf();
        RD1_rf = $urandom;
        RD2_rf = $urandom;
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; hold = 1'b0;
        A1 = 5'd7; A2 = 5'd0;
        new_rf();
        repeat (2) @(negedge clk);
        n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (We !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", We); end
        n_checks++; if ({A3, WD} !== '0) begin n_fail++; $display("FAIL reset_a3_wd: got %0d/%h expected 0/0", A3, WD); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (RD1 !== RD1_rf) begin n_fail++; $display("FAIL reset_rd1: got %h expected %h", RD1, RD1_rf); end
        n_checks++; if (RD2 !== '0) begin n_fail++; $display("FAIL reset_rd2_a0: got %h expected 0", RD2); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        offer(5'd5, 32'h1234_5678);
        hold = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (We !== 1'b1 || A3 !== 5'd5 || WD !== 32'h1234_5678) begin
            n_fail++; $display("FAIL single_commit: got We=%b A3=%0d WD=%h expected 1/5/12345678", We, A3, WD);
        end
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
        @(negedge clk);
        n_checks++; if (empty !== 1'b1 || We !== 1'b0) begin
            n_fail++; $display("FAIL single_drained: got empty=%b We=%b expected 1/0", empty, We);
        end
    endtask

    task automatic test_hold_fill();
        logic [AW-1:0] a_tab [4] = '{5'd3, 5'd3, 5'd7, 5'd9};
        logic [DW-1:0] d_tab [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        for (int i = 0; i < 4; i++) begin
            step();
            hold = 1'b1;
            offer(a_tab[i], d_tab[i]);
        end
        step();
        in_valid = 1'b0;
        A1 = 5'd3; A2 = 5'd7;
        new_rf();
        @(negedge clk);
        n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        n_checks++; if (We !== 1'b0) begin n_fail++; $display("FAIL hold_we: got %b expected 0", We); end
        n_checks++; if (RD1 !== 32'hB) begin n_fail++; $display("FAIL bypass_newest: got %h expected b", RD1); end
        n_checks++; if (RD2 !== 32'hC) begin n_fail++; $display("FAIL bypass_rd2: got %h expected c", RD2); end
        step();
        offer(5'd4, 32'hE);
        A1 = 5'd4; A2 = 5'd5;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_ready: got %b expected 0", in_ready); end
        n_checks++; if (RD2 !== RD2_rf) begin n_fail++; $display("FAIL bypass_miss: got %h expected %h", RD2, RD2_rf); end
        step();
        hold = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b expected 1", in_ready); end
        n_checks++; if (We !== 1'b1 || A3 !== 5'd3 || WD !== 32'hA) begin
            n_fail++; $display("FAIL full_pop_head: got We=%b A3=%0d WD=%h expected 1/3/a", We, A3, WD);
        end
        n_checks++; if (RD1 !== RD1_rf) begin n_fail++; $display("FAIL same_cycle_push_not_bypassed: got %h expected %h", RD1, RD1_rf); end
        step();
        in_valid = 1'b0;
        A2 = 5'd3;
        @(negedge clk);
        n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL push_pop_count: got %0d expected 4", count); end
        n_checks++; if (RD1 !== 32'hE) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected e", RD1); end
        n_checks++; if (We !== 1'b1 || RD2 !== 32'hB) begin
            n_fail++; $display("FAIL bypass_head_committing: got We=%b RD2=%h expected 1/b", We, RD2);
        end
        for (int c = 0; c < 20 && !empty; c++) @(negedge clk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_timeout: got empty=%b expected 1", empty); end
    endtask

    task automatic test_addr_zero();
        step();
        offer(5'd0, 32'hFFFF_FFFF);
        A1 = 5'd0;
        new_rf();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b expected 1", in_ready); end
        n_checks++; if (RD1 !== '0) begin n_fail++; $display("FAIL zero_rd1: got %h expected 0", RD1); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== CW'(0) || empty !== 1'b1 || We !== 1'b0) begin
            n_fail++; $display("FAIL zero_discard: got count=%0d empty=%b We=%b expected 0/1/0", count, empty, We);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            hold = 1'b1;
            offer(AW'(3 + 5 * i), $urandom);
        end
        step();
        in_valid = 1'b0;
        hold = 1'b0;
        A1 = 5'd3;
        new_rf();
        #1;
        n_checks++; if (We !== 1'b1 || count !== CW'(3)) begin
            n_fail++; $display("FAIL pre_reset: got We=%b count=%0d expected 1/3", We, count);
        end
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_checks++; if (count !== CW'(0) || We !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: got count=%0d We=%b empty=%b expected 0/0/1", count, We, empty);
        end
        n_checks++; if (RD1 !== RD1_rf) begin n_fail++; $display("FAIL async_reset_rd1: got %h expected %h", RD1, RD1_rf); end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_commits;
        hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            offer(AW'($urandom_range(1, 31)), $urandom);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1 || count > CW'(1)) begin
                n_fail++; $display("FAIL stream_%0d: got ready=%b count=%0d expected 1/<=1", i, in_ready, count);
            end
        end
        step();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (n_commits - base != 10) begin
            n_fail++; $display("FAIL stream_commits: got %0d expected 10", n_commits - base);
        end
        n_checks++; if (exp_q.size() != 0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL stream_leftover: got %0d pending, empty=%b expected 0/1", exp_q.size(), empty);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_hold_fill();
        test_addr_zero();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
